// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding and status codes for the ALU command sequencer
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_A     = 3'd1,
        ST_GET_B     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT      = 3'd4,
        ST_SEND_STAT = 3'd5,
        ST_SEND_RES  = 3'd6
    } seq_state_t;

    localparam logic [7:0] STATUS_OK    = 8'h00;
    localparam logic [7:0] STATUS_TMO   = 8'hFF;
    localparam logic [3:0] SYNC_DEFAULT = 4'hA;

endpackage

// File: rtl/alu_seq_tx_ser.sv
// rtl/alu_seq_tx_ser.sv - response serializer: status byte then 2*WIDTH result, LSB first
module alu_seq_tx_ser
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic               clk,
    input  logic               RST,
    input  logic               load,
    input  logic [2*WIDTH-1:0] res_in,
    input  logic [7:0]         stat_in,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               stat_done,
    output logic               res_done
);

    // Index 0 is the status byte, indices 1..NB are result bytes
    localparam int NB = WIDTH / 4;
    localparam int IW = $clog2(NB) + 1;

    logic [2*WIDTH-1:0] res;
    logic [7:0]         status;
    logic [IW-1:0]      idx;
    logic               active;
    logic [7:0]         byte_sel;

    // Capture response on load, advance only on handshake so data holds while stalled
    always_ff @(posedge clk) begin
        if (RST) begin
            res    <= '0;
            status <= STATUS_OK;
            idx    <= '0;
            active <= 1'b0;
        end else if (load) begin
            res    <= res_in;
            status <= stat_in;
            idx    <= '0;
            active <= 1'b1;
        end else if (active && tx_ready) begin
            if (idx == IW'(NB)) begin
                active <= 1'b0;
                idx    <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Select the byte at the current index
    always_comb begin
        byte_sel = status;
        for (int k = 0; k < NB; k++) begin
            if (idx == IW'(k + 1)) byte_sel = res[8*k +: 8];
        end
    end

    assign tx_valid  = active;
    assign tx_data   = active ? byte_sel : 8'h00;
    assign stat_done = active && tx_ready && (idx == '0);
    assign res_done  = active && tx_ready && (idx == IW'(NB));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - byte-framed command master driving the ALU and returning its result
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int         WIDTH   = 16,
    parameter int         TIMEOUT = 15,
    parameter logic [3:0] SYNC    = SYNC_DEFAULT
)(
    input  logic               clk,
    input  logic               RST,
    input  logic [7:0]         RX_DATA,
    input  logic               RX_VALID,
    output logic               RX_READY,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [3:0]         ALU_FUN,
    output logic               Enable,
    input  logic [2*WIDTH-1:0] ALU_OUT,
    input  logic               OUT_VALID,
    output logic [7:0]         TX_DATA,
    output logic               TX_VALID,
    input  logic               TX_READY,
    output logic               BUSY,
    output logic               ERR
);

    localparam int N  = WIDTH / 8;
    localparam int CW = $clog2(2 * N) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    seq_state_t         state, next_state;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      tmo;
    logic               err_q;
    logic               rx_fire, sync_ok, last_byte, tmo_exp;
    logic               tx_load, stat_done, res_done;
    logic [2*WIDTH-1:0] tx_res_in;
    logic [7:0]         tx_stat_in;

    assign rx_fire   = RX_VALID && RX_READY;
    assign sync_ok   = (RX_DATA[7:4] == SYNC);
    assign last_byte = (cnt == CW'(N - 1));
    assign tmo_exp   = (tmo == TW'(TIMEOUT - 1));
    assign ERR       = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; OUT_VALID takes priority over timeout expiry
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (rx_fire && sync_ok)   next_state = ST_GET_A;
            ST_GET_A:     if (rx_fire && last_byte) next_state = ST_GET_B;
            ST_GET_B:     if (rx_fire && last_byte) next_state = ST_ISSUE;
            ST_ISSUE:                               next_state = ST_WAIT;
            ST_WAIT:      if (OUT_VALID || tmo_exp) next_state = ST_SEND_STAT;
            ST_SEND_STAT: if (stat_done)            next_state = ST_SEND_RES;
            ST_SEND_RES:  if (res_done)             next_state = ST_IDLE;
            default:                                next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        RX_READY   = (state == ST_IDLE) || (state == ST_GET_A) || (state == ST_GET_B);
        Enable     = (state == ST_ISSUE);
        BUSY       = (state != ST_IDLE);
        tx_load    = (state == ST_WAIT) && (OUT_VALID || tmo_exp);
        tx_res_in  = OUT_VALID ? ALU_OUT : '0;
        tx_stat_in = OUT_VALID ? STATUS_OK : STATUS_TMO;
    end

    // Operand assembly, byte and timeout counters, error pulse
    always_ff @(posedge clk) begin
        if (RST) begin
            A       <= '0;
            B       <= '0;
            ALU_FUN <= '0;
            cnt     <= '0;
            tmo     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        if (sync_ok) begin
                            ALU_FUN <= RX_DATA[3:0];
                            cnt     <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_GET_A, ST_GET_B: begin
                    if (rx_fire) begin
                        for (int k = 0; k < N; k++) begin
                            if (cnt == CW'(k)) begin
                                if (state == ST_GET_A) A[8*k +: 8] <= RX_DATA;
                                else                   B[8*k +: 8] <= RX_DATA;
                            end
                        end
                        cnt <= last_byte ? '0 : cnt + CW'(1);
                    end
                end
                ST_ISSUE: tmo <= '0;
                ST_WAIT: begin
                    if (!OUT_VALID) begin
                        if (tmo_exp) err_q <= 1'b1;
                        else         tmo   <= tmo + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    alu_seq_tx_ser #(.WIDTH(WIDTH)) u_tx_ser (
        .clk       (clk),
        .RST       (RST),
        .load      (tx_load),
        .res_in    (tx_res_in),
        .stat_in   (tx_stat_in),
        .tx_data   (TX_DATA),
        .tx_valid  (TX_VALID),
        .tx_ready  (TX_READY),
        .stat_done (stat_done),
        .res_done  (res_done)
    );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           RST;
    logic [7:0]     RX_DATA;
    logic           RX_VALID;
    logic           RX_READY;
    logic [W-1:0]   A, B;
    logic [3:0]     ALU_FUN;
    logic           Enable;
    logic [2*W-1:0] ALU_OUT;
    logic           OUT_VALID;
    logic [7:0]     TX_DATA;
    logic           TX_VALID;
    logic           TX_READY;
    logic           BUSY;
    logic           ERR;

    alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT(15), .SYNC(4'hA)) dut (
        .clk(clk), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .Enable(Enable), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'd0:    alu_model = {16'h0, a} + {16'h0, b};
            4'd1:    alu_model = {16'h0, a - b};
            default: alu_model = {16'h0, a} * {16'h0, b};
        endcase
    endfunction

    // ALU model: registered, OUT_VALID 'lat' cycles after Enable (lat=0 means never)
    int          lat = 2;
    int          cd = 0;
    logic        ov_model = 1'b0;
    logic        ov_force = 1'b0;
    logic [31:0] alu_res = '0;

    always @(posedge clk) begin
        if (RST) begin
            ov_model <= 1'b0;
            cd       <= 0;
        end else if (Enable) begin
            ov_model <= 1'b0;
            alu_res  <= alu_model(ALU_FUN, A, B);
            cd       <= (lat > 0) ? lat - 1 : 0;
        end else if (cd == 1) begin
            ov_model <= 1'b1;
            cd       <= 0;
        end else begin
            ov_model <= 1'b0;
            if (cd > 1) cd <= cd - 1;
        end
    end

    assign OUT_VALID = ov_model | ov_force;
    assign ALU_OUT   = alu_res;

    logic [7:0]  exp_tx[$];
    logic [35:0] exp_op[$];

    int         err_seen = 0;
    int         wait_cyc = 0;
    int         tx_hs = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    // Monitor: scoreboard pops on TX handshakes and Enable strobes, hold rule, event counters
    always @(negedge clk) begin
        logic [35:0] e;
        if (prev_stall) begin
            check_val("hold_valid", TX_VALID, 1);
            check_val("hold_data", TX_DATA, prev_data);
        end
        prev_stall = TX_VALID && !TX_READY;
        prev_data  = TX_DATA;
        if (TX_VALID && TX_READY) begin
            tx_hs++;
            if (exp_tx.size() == 0) check_val("tx_unexpected", exp_tx.size(), 1);
            else                    check_val("tx_byte", TX_DATA, exp_tx.pop_front());
        end
        if (Enable) begin
            if (exp_op.size() == 0) begin
                check_val("en_unexpected", exp_op.size(), 1);
            end else begin
                e = exp_op.pop_front();
                check_val("alu_fun", ALU_FUN, e[35:32]);
                check_val("op_a", A, e[31:16]);
                check_val("op_b", B, e[15:0]);
            end
        end
        if (ERR) err_seen++;
        if (BUSY && !RX_READY && !Enable && !TX_VALID) wait_cyc++;
    end

    task automatic send_byte(input logic [7:0] d);
        logic rdy;
        int   n;
        RX_DATA  = d;
        RX_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = RX_READY;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        check_val("rx_accept", rdy, 1);
        RX_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                              input int latency, input bit expect_tx);
        logic [31:0] r;
        lat = latency;
        exp_op.push_back({f, a, b});
        if (expect_tx) begin
            r = (latency == 0) ? 32'h0 : alu_model(f, a, b);
            exp_tx.push_back((latency == 0) ? 8'hFF : 8'h00);
            for (int k = 0; k < 4; k++) exp_tx.push_back(r[8*k +: 8]);
        end
        send_byte({4'hA, f});
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check_val({tag, "_drain"}, exp_tx.size(), 0);
        @(negedge clk);
        check_val({tag, "_busy"}, BUSY, 0);
        check_val({tag, "_txv"}, TX_VALID, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        RST = 1'b1; RX_VALID = 1'b0; RX_DATA = '0; TX_READY = 1'b1;
        repeat (3) @(posedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
        check_val("rst_rx_ready", RX_READY, 1);
        check_val("rst_busy", BUSY, 0);
        check_val("rst_txv", TX_VALID, 0);
        check_val("rst_txd", TX_DATA, 0);
        check_val("rst_en", Enable, 0);
        check_val("rst_err", ERR, 0);
        check_val("rst_abf", {A, B, ALU_FUN}, 0);
        @(posedge clk); #1;

        // Basic add frame
        wait_cyc = 0; err_seen = 0;
        send_frame(4'h0, 16'h1234, 16'h0005, 2, 1);
        wait_done("t1");
        check_val("t1_wait", wait_cyc, 2);
        check_val("t1_err", err_seen, 0);

        // Bad sync byte then a valid subtract frame
        err_seen = 0;
        send_byte(8'h53);
        check_val("t2_no_op", exp_op.size(), 0);
        send_frame(4'h1, 16'h000F, 16'h000F, 2, 1);
        wait_done("t2");
        check_val("t2_err", err_seen, 1);

        // Timeout: ALU never answers
        wait_cyc = 0; err_seen = 0;
        send_frame(4'h2, 16'h0003, 16'h0004, 0, 1);
        wait_done("t3");
        check_val("t3_wait", wait_cyc, 15);
        check_val("t3_err", err_seen, 1);

        // OUT_VALID on the last WAIT cycle wins over timeout
        wait_cyc = 0; err_seen = 0;
        send_frame(4'h2, 16'h0102, 16'h0304, 15, 1);
        wait_done("t4");
        check_val("t4_wait", wait_cyc, 15);
        check_val("t4_err", err_seen, 0);

        // Back-pressure during second result byte
        base = tx_hs;
        send_frame(4'h2, 16'h1234, 16'h0111, 2, 1);
        n = 0;
        while (tx_hs < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_reach", tx_hs - base, 2);
        @(posedge clk); #1 TX_READY = 1'b0;
        repeat (5) @(posedge clk);
        #1 TX_READY = 1'b1;
        wait_done("t5");

        // Reset mid-WAIT, then a stray OUT_VALID pulse
        err_seen = 0;
        send_frame(4'h3, 16'h0011, 16'h0022, 0, 0);
        repeat (4) @(posedge clk);
        #1 RST = 1'b1;
        @(posedge clk);
        #1 RST = 1'b0; ov_force = 1'b1;
        @(negedge clk);
        check_val("t6_busy", BUSY, 0);
        check_val("t6_txv", TX_VALID, 0);
        check_val("t6_rx_ready", RX_READY, 1);
        check_val("t6_en", Enable, 0);
        check_val("t6_abf", {A, B, ALU_FUN}, 0);
        @(posedge clk); #1 ov_force = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("t6_idle_busy", BUSY, 0);
        check_val("t6_idle_txv", TX_VALID, 0);
        check_val("t6_err", err_seen, 0);
        @(posedge clk); #1;
        send_frame(4'h1, 16'h5000, 16'h0123, 2, 1);
        wait_done("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
